gpio_bus_initiator: RTL and testbench

Host-side initiator driving the GPIO register bus (write strobe, address, write data, combinational read data) into the GPIO register block. Accepts read/write commands through a valid/ready command port and buffers them in a small FIFO. Issues one single-cycle bus transaction per command and returns read data on a valid/ready response port. Optionally auto-services the GPIO interrupt line by reading the interrupt-status register (0x1C).

---
 rtl/gpio_reg_pkg.sv | 27 ++
 rtl/gpio_cmd_fifo.sv | 54 +++++
 rtl/gpio_bus_initiator.sv | 146 ++++++++++++++
 tb/tb_gpio_bus_initiator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_reg_pkg.sv
// Shared definitions for the GPIO register bus: register map, CTRL bit
// positions and the bus-initiator FSM state encoding.
package gpio_reg_pkg;

   localparam logic [31:0] RGPIO_IN    = 32'h00;
   localparam logic [31:0] RGPIO_OUT   = 32'h04;
   localparam logic [31:0] RGPIO_OE    = 32'h08;
   localparam logic [31:0] RGPIO_INTE  = 32'h0C;
   localparam logic [31:0] RGPIO_PTRIG = 32'h10;
   localparam logic [31:0] RGPIO_AUX   = 32'h14;
   localparam logic [31:0] RGPIO_CTRL  = 32'h18;
   localparam logic [31:0] RGPIO_INTS  = 32'h1C;
   localparam logic [31:0] RGPIO_ECLK  = 32'h20;
   localparam logic [31:0] RGPIO_NEC   = 32'h24;

   localparam int RGPIO_CTRL_INTE = 0;
   localparam int RGPIO_CTRL_INTS = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUS,
      ST_RESP,
      ST_IRQ_BUS,
      ST_IRQ_RESP
   } state_e;

endpackage

// File: rtl/gpio_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; the count carries one
// extra bit so a completely full FIFO is representable.
module gpio_cmd_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int W          = 65,
   localparam int PW        = $clog2(FIFO_DEPTH)
) (
   input  logic          sysclk,
   input  logic          sysrst_n,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [PW:0]   level_o
);

   localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);

   logic [W-1:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   level_q;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + (PW+1)'(1);
            2'b01:   level_q <= level_q - (PW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge sysclk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/gpio_bus_initiator.sv
// Host-side initiator for the GPIO register bus: queues commands, issues one
// registered single-cycle bus transaction each, and optionally services irqs.
module gpio_bus_initiator
   import gpio_reg_pkg::*;
#(
   parameter int                FIFO_DEPTH = 4,
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] INTS_ADDR  = ADDR_W'(RGPIO_INTS),
   localparam int               LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              sysclk,
   input  logic              sysrst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_irq,
   input  logic              irq_svc_en,
   input  logic              gpio_inta_i,
   output logic              gpio_we_o,
   output logic [ADDR_W-1:0] gpio_addr_o,
   output logic [DATA_W-1:0] gpio_wdat_o,
   input  logic [DATA_W-1:0] gpio_rdat_i,
   output logic              busy,
   output logic [LW-1:0]     fifo_level
);

   localparam int FW = 1 + ADDR_W + DATA_W;

   state_e            state_q;
   logic              irq_block_q;
   logic              rsp_valid_q, rsp_irq_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [ADDR_W-1:0] rsp_addr_q;
   logic              gpio_we_q;
   logic [ADDR_W-1:0] gpio_addr_q;
   logic [DATA_W-1:0] gpio_wdat_q;

   logic              fifo_full, fifo_empty, fifo_pop, irq_take;
   logic [FW-1:0]     fifo_dout;
   logic              f_we;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_wdata;

   assign {f_we, f_addr, f_wdata} = fifo_dout;

   // Interrupt service outranks queued commands; one service per assertion.
   assign irq_take = irq_svc_en && gpio_inta_i && !irq_block_q;
   assign fifo_pop = (state_q == ST_IDLE) && !irq_take && !fifo_empty;

   gpio_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .W          (FW)
   ) u_fifo (
      .sysclk   (sysclk),
      .sysrst_n (sysrst_n),
      .push_i   (cmd_valid),
      .din_i    ({cmd_we, cmd_addr, cmd_wdata}),
      .pop_i    (fifo_pop),
      .dout_o   (fifo_dout),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .level_o  (fifo_level)
   );

   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         state_q     <= ST_IDLE;
         irq_block_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_irq_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_addr_q  <= '0;
         gpio_we_q   <= 1'b0;
         gpio_addr_q <= '0;
         gpio_wdat_q <= '0;
      end else begin
         if (!gpio_inta_i) irq_block_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (irq_take) begin
                  gpio_addr_q <= INTS_ADDR;
                  gpio_we_q   <= 1'b0;
                  state_q     <= ST_IRQ_BUS;
               end else if (!fifo_empty) begin
                  gpio_addr_q <= f_addr;
                  gpio_wdat_q <= f_wdata;
                  gpio_we_q   <= f_we;
                  state_q     <= ST_BUS;
               end
            end
            ST_BUS: begin
               gpio_we_q <= 1'b0;
               if (gpio_we_q) begin
                  state_q <= ST_IDLE;
               end else begin
                  rsp_rdata_q <= gpio_rdat_i;
                  rsp_addr_q  <= gpio_addr_q;
                  rsp_irq_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_IRQ_BUS: begin
               rsp_rdata_q <= gpio_rdat_i;
               rsp_addr_q  <= gpio_addr_q;
               rsp_irq_q   <= 1'b1;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_IRQ_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            ST_IRQ_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
                  // A line already low has ended its episode; leave unblocked.
                  if (gpio_inta_i) irq_block_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = !fifo_full;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_irq     = rsp_irq_q;
   assign gpio_we_o   = gpio_we_q;
   assign gpio_addr_o = gpio_addr_q;
   assign gpio_wdat_o = gpio_wdat_q;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpio_bus_initiator.sv
// Directed bench for gpio_bus_initiator with a response scoreboard and a
// behavioural register target returning address-dependent read data.
module tb_gpio_bus_initiator;

   logic        sysclk = 1'b0;
   logic        sysrst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_irq;
   logic [31:0] rsp_rdata, rsp_addr;
   logic        irq_svc_en, gpio_inta_i;
   logic        gpio_we_o;
   logic [31:0] gpio_addr_o, gpio_wdat_o, gpio_rdat_i;
   logic        busy;
   logic [2:0]  fifo_level;

   always #5 sysclk = ~sysclk;

   gpio_bus_initiator dut (
      .sysclk      (sysclk),
      .sysrst_n    (sysrst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_addr    (rsp_addr),
      .rsp_irq     (rsp_irq),
      .irq_svc_en  (irq_svc_en),
      .gpio_inta_i (gpio_inta_i),
      .gpio_we_o   (gpio_we_o),
      .gpio_addr_o (gpio_addr_o),
      .gpio_wdat_o (gpio_wdat_o),
      .gpio_rdat_i (gpio_rdat_i),
      .busy        (busy),
      .fifo_level  (fifo_level)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] a;
      logic        irq;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          we_cnt  = 0;
   int          rsp_cnt = 0;
   int          rsp_base;
   logic [31:0] we_addr, we_data;
   logic        acc;

   function automatic logic [31:0] tgt(input logic [31:0] addr);
      return 32'h1234_5678 ^ {4{addr[7:0]}};
   endfunction

   assign gpio_rdat_i = tgt(gpio_addr_o);

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic accepted);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_wdata = wd;
      accepted  = cmd_ready;
      if (accepted && !we) exp_q.push_back('{d: tgt(addr), a: addr, irq: 1'b0});
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) tick();
      check("drain_queue_empty", 72'(exp_q.size()), 72'd0);
      check("drain_not_busy", 72'(busy), 72'd0);
   endtask

   // Scoreboard side: every accepted response must match the oldest expectation.
   always @(negedge sysclk) begin
      if (sysrst_n) begin
         if (gpio_we_o) begin
            we_cnt++;
            we_addr = gpio_addr_o;
            we_data = gpio_wdat_o;
         end
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            check("rsp_expected", 72'(exp_q.size() != 0), 72'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("rsp_payload", 72'({rsp_rdata, rsp_addr, rsp_irq}), 72'(mon_e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid   = 1'b0;
      cmd_we      = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      rsp_ready   = 1'b1;
      irq_svc_en  = 1'b0;
      gpio_inta_i = 1'b0;
      sysrst_n    = 1'b0;
      repeat (2) tick();

      check("rst_rsp_valid", 72'(rsp_valid), 72'd0);
      check("rst_gpio_we", 72'(gpio_we_o), 72'd0);
      check("rst_gpio_addr", 72'(gpio_addr_o), 72'd0);
      check("rst_gpio_wdat", 72'(gpio_wdat_o), 72'd0);
      check("rst_rsp_fields", 72'({rsp_rdata, rsp_addr, rsp_irq}), 72'd0);
      check("rst_busy", 72'(busy), 72'd0);
      check("rst_cmd_ready", 72'(cmd_ready), 72'd1);
      check("rst_level", 72'(fifo_level), 72'd0);
      sysrst_n = 1'b1;
      tick();

      // Single write: one strobe cycle, no response.
      push_cmd(1'b1, 32'h04, 32'hA5A5_0000, acc);
      check("wr_accepted", 72'(acc), 72'd1);
      for (int i = 0; i < 4; i++) begin
         check("wr_no_rsp", 72'(rsp_valid), 72'd0);
         tick();
      end
      check("wr_pulse_count", 72'(we_cnt), 72'd1);
      check("wr_addr", 72'(we_addr), 72'h04);
      check("wr_data", 72'(we_data), 72'hA5A5_0000);
      check("wr_we_low", 72'(gpio_we_o), 72'd0);

      // Single read with exact latency and hold until accepted.
      rsp_ready = 1'b0;
      push_cmd(1'b0, 32'h00, 32'h0, acc);
      tick();
      check("rd_bus_no_rsp", 72'(rsp_valid), 72'd0);
      check("rd_bus_addr", 72'(gpio_addr_o), 72'h00);
      tick();
      check("rd_rsp_valid", 72'(rsp_valid), 72'd1);
      check("rd_rsp_data", 72'(rsp_rdata), 72'h1234_5678);
      check("rd_rsp_addr", 72'(rsp_addr), 72'h00);
      check("rd_rsp_irq", 72'(rsp_irq), 72'd0);
      tick();
      check("rd_hold_valid", 72'(rsp_valid), 72'd1);
      rsp_ready = 1'b1;
      tick();
      check("rd_clear", 72'(rsp_valid), 72'd0);
      check("rd_consumed", 72'(rsp_cnt), 72'd1);

      // Six reads while responses stall: five accepted, FIFO full.
      rsp_ready = 1'b0;
      rsp_base  = rsp_cnt;
      for (int i = 0; i < 6; i++) begin
         push_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0, acc);
         check("fill_accept", 72'(acc), 72'(i < 5));
      end
      check("fill_cmd_ready", 72'(cmd_ready), 72'd0);
      check("fill_level", 72'(fifo_level), 72'd4);
      check("fill_rsp_addr", 72'(rsp_addr), 72'h10);
      rsp_ready = 1'b1;
      tick();
      check("full_after_hs_ready", 72'(cmd_ready), 72'd0);
      check("full_after_hs_level", 72'(fifo_level), 72'd4);
      // Push offered in the same cycle as a pop from a full FIFO is refused.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_addr  = 32'h80;
      tick();
      cmd_valid = 1'b0;
      check("full_pop_level", 72'(fifo_level), 72'd3);
      check("full_pop_ready", 72'(cmd_ready), 72'd1);
      drain();
      check("fill_rsp_count", 72'(rsp_cnt - rsp_base), 72'd5);
      check("fill_level_zero", 72'(fifo_level), 72'd0);

      // Push and pop together at level 1.
      push_cmd(1'b0, 32'h20, 32'h0, acc);
      check("lvl1_level", 72'(fifo_level), 72'd1);
      push_cmd(1'b0, 32'h24, 32'h0, acc);
      check("lvl1_pushpop_level", 72'(fifo_level), 72'd1);
      check("lvl1_pushpop_ready", 72'(cmd_ready), 72'd1);
      drain();

      // Interrupt service precedes a queued read, once per episode.
      irq_svc_en  = 1'b1;
      rsp_base    = rsp_cnt;
      exp_q.push_back('{d: tgt(32'h1C), a: 32'h1C, irq: 1'b1});
      gpio_inta_i = 1'b1;
      push_cmd(1'b0, 32'h08, 32'h0, acc);
      drain();
      check("irq_first_count", 72'(rsp_cnt - rsp_base), 72'd2);
      repeat (8) tick();
      check("irq_no_repeat", 72'(rsp_cnt - rsp_base), 72'd2);
      check("irq_idle", 72'(busy), 72'd0);
      gpio_inta_i = 1'b0;
      tick();
      exp_q.push_back('{d: tgt(32'h1C), a: 32'h1C, irq: 1'b1});
      gpio_inta_i = 1'b1;
      tick();
      drain();
      check("irq_reservice_count", 72'(rsp_cnt - rsp_base), 72'd3);
      gpio_inta_i = 1'b0;
      irq_svc_en  = 1'b0;
      tick();

      // Asynchronous reset while a response is pending with commands queued.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'(4 * i), 32'h0, acc);
      check("prerst_rsp_valid", 72'(rsp_valid), 72'd1);
      check("prerst_level", 72'(fifo_level), 72'd3);
      exp_q.delete();
      sysrst_n = 1'b0;
      #1;
      check("arst_rsp_valid", 72'(rsp_valid), 72'd0);
      check("arst_gpio_we", 72'(gpio_we_o), 72'd0);
      check("arst_level", 72'(fifo_level), 72'd0);
      check("arst_busy", 72'(busy), 72'd0);
      check("arst_cmd_ready", 72'(cmd_ready), 72'd1);
      tick();
      sysrst_n  = 1'b1;
      rsp_ready = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
